// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences one instruction
// over 3-5 cycles and decodes every datapath select and write enable from state.
module multicycle_control #(
   parameter int W_STATE  = 4,
   parameter int OP_WIDTH = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OP_WIDTH-1:0] opcode,
   input  logic                mem_ready,
   output logic                pcwrite,
   output logic                branch,
   output logic                iord,
   output logic                memwrite,
   output logic                irwrite,
   output logic                regdst,
   output logic                memtoreg,
   output logic                regwrite,
   output logic                alusrca,
   output logic [1:0]          alusrcb,
   output logic [1:0]          aluop,
   output logic [1:0]          pcsrc,
   output logic                instr_done,
   output logic                illegal_op,
   output logic [W_STATE-1:0]  state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BEQ    = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [OP_WIDTH-1:0] OP_R    = OP_WIDTH'(6'b000000);
   localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(6'b100011);
   localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(6'b101011);
   localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(6'b000100);
   localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(6'b001000);
   localparam logic [OP_WIDTH-1:0] OP_J    = OP_WIDTH'(6'b000010);

   state_t state_q, state_d;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   assign state = W_STATE'(state_q);

   always_comb begin
      state_d    = S_FETCH;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      aluop      = 2'b00;
      pcsrc      = 2'b00;
      instr_done = 1'b0;
      illegal_op = 1'b0;

      case (state_q)
         S_FETCH: begin
            alusrcb = 2'b01;
            irwrite = mem_ready;
            pcwrite = mem_ready;
            state_d = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            // ALU precomputes the branch target while the opcode is decoded
            alusrcb = 2'b11;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXEC;
               OP_BEQ:       state_d = S_BEQ;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default: begin
                  illegal_op = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            iord    = 1'b1;
            state_d = mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            memtoreg   = 1'b1;
            regwrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWR: begin
            iord       = 1'b1;
            memwrite   = 1'b1;
            instr_done = mem_ready;
            state_d    = mem_ready ? S_FETCH : S_MEMWR;
         end
         S_EXEC: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            regdst     = 1'b1;
            regwrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_BEQ: begin
            alusrca    = 1'b1;
            aluop      = 2'b01;
            pcsrc      = 2'b01;
            branch     = 1'b1;
            instr_done = 1'b1;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            regwrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_JUMP: begin
            pcsrc      = 2'b10;
            pcwrite    = 1'b1;
            instr_done = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: steps each instruction class through
// the FSM and checks state and decoded controls against hand-derived values.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg;
   logic       regwrite, alusrca, instr_done, illegal_op;
   logic [1:0] alusrcb, aluop, pcsrc;
   logic [3:0] state;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned irw_cnt;
   int unsigned cyc_cnt;

   multicycle_control #(.W_STATE(4), .OP_WIDTH(6)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .pcwrite(pcwrite), .branch(branch), .iord(iord), .memwrite(memwrite),
      .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
      .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
      .aluop(aluop), .pcsrc(pcsrc), .instr_done(instr_done),
      .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   // strobe vector: {pcwrite, branch, memwrite, irwrite, regwrite, instr_done, illegal_op}
   wire [6:0] strobes = {pcwrite, branch, memwrite, irwrite, regwrite, instr_done, illegal_op};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance one clock; outputs are examined 1 time unit after the edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; mem_ready = 1'b0; opcode = 6'b000000;
      cyc(); cyc();
      rst = 1'b0; #1;
      chk("init_state", state, 0);
      chk("init_strobes", strobes, 0);

      // drive into MEMWR (state 5) and stall there
      opcode = 6'b101011; mem_ready = 1'b1; #1;
      chk("fetch_irwrite", irwrite, 1);
      chk("fetch_pcwrite", pcwrite, 1);
      chk("fetch_alusrcb", alusrcb, 2'b01);
      cyc(); chk("sw0_decode", state, 1);
      chk("decode_alusrcb", alusrcb, 2'b11);
      chk("decode_illegal", illegal_op, 0);
      cyc(); chk("sw0_memadr", state, 2);
      chk("memadr_srcs", {alusrca, alusrcb}, 3'b110);
      cyc(); chk("sw0_memwr", state, 5);
      mem_ready = 1'b0; #1;
      chk("memwr_stall_memwrite", memwrite, 1);
      chk("memwr_stall_done", instr_done, 0);
      rst = 1'b1;
      cyc(); cyc();
      rst = 1'b0; #1;
      chk("rst_from5_state", state, 0);
      chk("rst_from5_strobes", strobes, 0);
      chk("fetch_stall_stays", state, 0);
      cyc();
      chk("fetch_stall_hold", state, 0);

      // R-type
      opcode = 6'b000000; mem_ready = 1'b1; irw_cnt = 0; #1;
      irw_cnt += irwrite; cyc(); chk("r_s1", state, 1);
      irw_cnt += irwrite; cyc(); chk("r_s6", state, 6);
      chk("exec_aluop", aluop, 2'b10);
      chk("exec_srcs", {alusrca, alusrcb}, 3'b100);
      irw_cnt += irwrite; cyc(); chk("r_s7", state, 7);
      chk("aluwb_ctl", {regdst, regwrite, instr_done, memtoreg}, 4'b1110);
      irw_cnt += irwrite; cyc(); chk("r_s0", state, 0);
      chk("r_irwrite_pulses", irw_cnt, 1);

      // lw with two MEMRD stalls; opcode scrambled during stalls
      opcode = 6'b100011; mem_ready = 1'b1;
      cyc(); chk("lw_s1", state, 1);
      cyc(); chk("lw_s2", state, 2);
      cyc(); chk("lw_s3a", state, 3);
      mem_ready = 1'b0; opcode = 6'b111111; #1;
      chk("lw_iord_a", iord, 1);
      cyc(); chk("lw_s3b", state, 3);
      chk("lw_iord_b", iord, 1);
      cyc(); chk("lw_s3c", state, 3);
      mem_ready = 1'b1; #1;
      chk("lw_iord_c", iord, 1);
      chk("memrd_no_strobe", strobes, 0);
      cyc(); chk("lw_s4", state, 4);
      chk("memwb_ctl", {memtoreg, regdst, regwrite, instr_done}, 4'b1011);
      cyc(); chk("lw_s0", state, 0);

      // sw with one MEMWR stall
      opcode = 6'b101011;
      cyc(); cyc(); cyc(); chk("sw_s5", state, 5);
      mem_ready = 1'b0; #1;
      chk("sw_mw1", {memwrite, instr_done, iord}, 3'b101);
      cyc(); chk("sw_s5b", state, 5);
      mem_ready = 1'b1; #1;
      chk("sw_mw2", {memwrite, instr_done, iord}, 3'b111);
      cyc(); chk("sw_s0", state, 0);

      // beq then j, back to back
      opcode = 6'b000100; cyc_cnt = 0;
      cyc(); cyc_cnt++; chk("beq_s1", state, 1);
      cyc(); cyc_cnt++; chk("beq_s8", state, 8);
      chk("beq_ctl", {aluop, branch, pcsrc, instr_done, alusrca}, 7'b0110111);
      opcode = 6'b000010;
      cyc(); cyc_cnt++; chk("j_s0", state, 0);
      cyc(); cyc_cnt++; chk("j_s1", state, 1);
      cyc(); cyc_cnt++; chk("j_s11", state, 11);
      chk("j_ctl", {pcsrc, pcwrite, instr_done}, 4'b1011);
      cyc(); cyc_cnt++; chk("j_back", state, 0);
      chk("beq_j_cycles", cyc_cnt, 6);

      // addi
      opcode = 6'b001000;
      cyc(); cyc(); chk("addi_s9", state, 9);
      chk("addiex_srcs", {alusrca, alusrcb, aluop}, 5'b11000);
      cyc(); chk("addi_s10", state, 10);
      chk("addiwb_ctl", {regdst, memtoreg, regwrite, instr_done}, 4'b0011);
      cyc(); chk("addi_s0", state, 0);

      // illegal opcode
      opcode = 6'b111111;
      cyc(); chk("ill_s1", state, 1);
      chk("ill_strobes", strobes, 7'b0000001);
      cyc(); chk("ill_s0", state, 0);

      // mid-lw reset from MEMRD, mem_ready high on the reset edge
      opcode = 6'b100011;
      cyc(); cyc(); cyc(); chk("lwr_s3", state, 3);
      rst = 1'b1; mem_ready = 1'b1;
      cyc(); chk("lwr_reset", state, 0);
      #1; chk("rst_fetch_irwrite", irwrite, 1);
      cyc(); chk("rst_wins_fetch", state, 0);
      rst = 1'b0;
      cyc(); chk("post_rst_decode", state, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences one instruction over 3–5 cycles. It drives every datapath select: the 5-bit register-destination mux (regdst), the memory address mux, the ALU operand muxes, the PC source mux and the writeback mux. It also drives all write enables. A mem_ready handshake stalls the FSM in memory states until the unified memory responds.

Parameters:
W_STATE, 4, width of state register and debug state output
OP_WIDTH, 6, opcode field width (instr[31:26])

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
opcode  input  OP_WIDTH  opcode from instruction register
mem_ready  input  1  memory read/write completes this cycle
pcwrite  output  1  unconditional PC write enable
branch  output  1  conditional PC write (ANDed with zero in datapath)
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
memwrite  output  1  memory write strobe
irwrite  output  1  instruction register load
regdst  output  1  write-register mux select: 0 = rt, 1 = rd
memtoreg  output  1  writeback mux select: 0 = ALUOut, 1 = MDR
regwrite  output  1  register file write enable
alusrca  output  1  ALU A select: 0 = PC, 1 = A
alusrcb  output  2  ALU B select: 00 = B, 01 = 4, 10 = signext, 11 = signext<<2
aluop  output  2  00 = add, 01 = sub, 10 = funct decode
pcsrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
instr_done  output  1  one-cycle pulse on an instruction's last cycle
illegal_op  output  1  one-cycle pulse in DECODE for an unsupported opcode
state  output  W_STATE  current state, for debug

Behaviour:
- Supported opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, addi = 001000, j = 000010.
- States and encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - EXEC = 6, ALUWB = 7, BEQ = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11
  - Encodings 12–15 are unused; any unused state goes to FETCH on the next edge.
- Reset:
  - rst high at a clock edge forces state = FETCH, regardless of the current state, including mid-stall.
  - There are no registered outputs besides state.
  - All outputs are decoded from state (plus mem_ready in memory states).
  - In FETCH with mem_ready = 0, every strobe is 0.
- Default for all outputs is 0 in every state unless listed below.
- FETCH:
  - iord = 0, alusrca = 0, alusrcb = 01, aluop = 00, pcsrc = 00.
  - irwrite = pcwrite = mem_ready.
  - Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
- DECODE:
  - alusrca = 0, alusrcb = 11, aluop = 00 (branch target precompute).
  - Next state: lw/sw → MEMADR; R → EXEC; beq → BEQ; addi → ADDIEX; j → JUMP.
  - Any other opcode: illegal_op = 1, next state FETCH, no write strobes asserted.
- MEMADR: alusrca = 1, alusrcb = 10, aluop = 00. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: iord = 1. Hold while mem_ready = 0; go to MEMWB when mem_ready = 1.
- MEMWB: regdst = 0, memtoreg = 1, regwrite = 1, instr_done = 1. Next state FETCH.
- MEMWR:
  - iord = 1, memwrite = 1 (held high while stalled).
  - When mem_ready = 1: instr_done = 1, next state FETCH.
- EXEC: alusrca = 1, alusrcb = 00, aluop = 10. Next state ALUWB.
- ALUWB: regdst = 1, memtoreg = 0, regwrite = 1, instr_done = 1. Next state FETCH.
- BEQ: alusrca = 1, alusrcb = 00, aluop = 01, pcsrc = 01, branch = 1, instr_done = 1. Next state FETCH.
- ADDIEX: alusrca = 1, alusrcb = 10, aluop = 00. Next state ADDIWB.
- ADDIWB: regdst = 0, memtoreg = 0, regwrite = 1, instr_done = 1. Next state FETCH.
- JUMP: pcsrc = 10, pcwrite = 1, instr_done = 1. Next state FETCH.
- Latency with mem_ready held at 1:
  - R and addi: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq and j: 3 cycles
  - Each mem_ready = 0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- opcode is sampled only in DECODE and MEMADR. opcode changes in other states have no effect.
- Simultaneous events:
  - mem_ready = 1 on the same edge as rst: reset wins.
  - pcwrite/irwrite are still asserted combinationally during that cycle. The datapath owns PC reset, so this is acceptable.

Test Plan:
- Reset: rst = 1 for 2 cycles from arbitrary state 5 → state = 0; with mem_ready = 0 all strobes = 0.
- R-type, mem_ready = 1, opcode = 000000:
  - state sequence 0, 1, 6, 7, 0.
  - In state 7: regdst = 1, regwrite = 1, instr_done = 1.
  - Exactly one irwrite pulse.
- lw with 2 stall cycles in MEMRD, opcode = 100011:
  - state sequence 0, 1, 2, 3, 3, 3, 4, 0.
  - In state 4: memtoreg = 1, regdst = 0.
  - iord = 1 for all three MEMRD cycles.
- sw, mem_ready low 1 cycle in MEMWR: memwrite high for 2 consecutive cycles, instr_done only on the second, then FETCH.
- beq then j back-to-back:
  - beq: aluop = 01, branch = 1, pcsrc = 01.
  - j: pcsrc = 10, pcwrite = 1.
  - Total 6 cycles.
- Illegal opcode 111111: illegal_op pulses in DECODE, returns to FETCH, regwrite/memwrite never asserted. Mid-lw rst in state 3 → FETCH next cycle.
